// File: rtl/x74_194_tx_ctrl_pkg.sv
// x74_tx_pkg: shared definitions for the x74_194 transmit sequencer.
// Holds the FSM state encoding, the x74_194 mode-pin encodings and the
// sizing helpers used by the controller and its bit timer.
// Related build macro: X74_TX_PARITY_EN (parity bit present when defined).

package x74_tx_pkg;

    // Frame sequencer states. PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // x74_194 mode pins, packed as {S0, S1}.
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;  // shift toward Q[3]
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Width of a counter that must hold 0..bit_div-1; never narrower than 1.
    function automatic int timer_width(input int bit_div);
        return (bit_div <= 2) ? 1 : $clog2(bit_div);
    endfunction

    // Only 1 or 2 stop bits exist; anything else falls back to a single one.
    function automatic int stop_count(input int stop_bits);
        return (stop_bits == 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/x74_194_tx_ctrl_timer.sv
// x74_bit_timer: divides the system clock into line-bit periods.
// Counts 0..BIT_DIV-1 and flags the final clock of each bit with bit_end.
// restart forces the count back to 0 so every state starts a fresh bit.

module x74_bit_timer
    import x74_tx_pkg::*;
#(
    parameter int BIT_DIV = 4
)
(
    input  logic CLK,
    input  logic CLR,
    input  logic restart,
    output logic bit_end
);

    localparam int             W    = timer_width(BIT_DIV);
    localparam logic [W-1:0]   LAST = W'(BIT_DIV - 1);

    logic [W-1:0] r_cnt;

    assign bit_end = (r_cnt == LAST);

    // Free-running modulo-BIT_DIV counter, cleared on restart or wrap.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_cnt <= '0;
        end else if (restart || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/x74_194_tx.sv
// x74_194_tx_ctrl: serial transmit frame sequencer driving an external
// x74_194 4-bit universal shift register.
// Frame on tx_line: start(0), 8 data bits MSB first, optional parity,
// STOP_BITS stop bits (1). Each bit lasts BIT_DIV clocks.
// The x74_194 carries the data bits: high nibble loaded at the end of
// START, shifted toward Q[3] each bit, low nibble reloaded after bit 3.
// Build macro X74_TX_PARITY_EN: when defined a parity bit follows the data.

module x74_194_tx_ctrl
    import x74_tx_pkg::*;
#(
    parameter int BIT_DIV    = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
)
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sr_s0,
    output logic       sr_s1,
    output logic       sr_a,
    output logic       sr_b,
    output logic       sr_c,
    output logic       sr_d,
    output logic       sr_sli,
    output logic       sr_clr_n,
    input  logic       sr_out,
    output logic       tx_line,
    output logic       busy,
    output logic       done
);

    localparam int         STOP_N    = stop_count(STOP_BITS);
    localparam logic [2:0] STOP_LAST = 3'(STOP_N - 1);
    localparam logic       PAR_SENSE = (PARITY_ODD != 0);

`ifdef X74_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = ST_PARITY;
`else
    localparam tx_state_t AFTER_DATA = ST_STOP;
`endif

    tx_state_t  r_state;
    tx_state_t  w_state_next;
    logic [7:0] r_byte;
    logic [2:0] r_bit_idx;     // data bit index in DATA, stop bit index in STOP

    logic       w_bit_end;
    logic       w_restart;
    logic       w_accept;
    logic       w_done;
    logic       w_parity;
    logic       w_line;
    logic [1:0] w_mode;
    logic [3:0] w_nib;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_parity = (^r_byte) ^ PAR_SENSE;
    assign w_done   = (r_state == ST_STOP) && w_bit_end && (r_bit_idx == STOP_LAST);

    // The timer restarts whenever the state changes and is parked at 0 in IDLE.
    assign w_restart = (r_state == ST_IDLE) || (w_state_next != r_state);

    x74_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .CLK     (CLK),
        .CLR     (CLR),
        .restart (w_restart),
        .bit_end (w_bit_end)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte latch: captured once at acceptance, later in_data changes ignored.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_byte <= 8'h00;
        end else if (w_accept) begin
            r_byte <= in_data;
        end
    end

    // Bit index: cleared on every state entry, advances once per bit.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_bit_idx <= 3'd0;
        end else if (w_restart) begin
            r_bit_idx <= 3'd0;
        end else if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Next state plus line level and x74_194 mode/data pins.
    always_comb begin
        w_state_next = r_state;
        w_line       = 1'b1;
        w_mode       = MODE_HOLD;
        w_nib        = 4'h0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_line = 1'b0;
                if (w_bit_end) begin
                    w_mode       = MODE_LOAD;
                    w_nib        = r_byte[7:4];
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                // Q[3] of the shift register is the current data bit.
                w_line = sr_out;
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd3) begin
                        w_mode = MODE_LOAD;
                        w_nib  = r_byte[3:0];
                    end else if (r_bit_idx == 3'd7) begin
                        w_mode       = MODE_HOLD;
                        w_state_next = AFTER_DATA;
                    end else begin
                        w_mode = MODE_SHIFT;
                    end
                end
            end
            ST_PARITY: begin
                w_line = w_parity;
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                w_line = 1'b1;
                if (w_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign done     = w_done;
    assign tx_line  = w_line;
    assign sr_s0    = w_mode[1];
    assign sr_s1    = w_mode[0];
    assign sr_a     = w_nib[3];
    assign sr_b     = w_nib[2];
    assign sr_c     = w_nib[1];
    assign sr_d     = w_nib[0];
    assign sr_sli   = 1'b0;
    // Shift register held in clear whenever no frame is running.
    assign sr_clr_n = (r_state != ST_IDLE);

endmodule

// File: tb/tb_x74_194_tx_ctrl.sv
// Testbench for x74_194_tx_ctrl with behavioural x74_194 shift registers.
// DUT A: BIT_DIV=4, STOP_BITS=1. DUT B: BIT_DIV=1, STOP_BITS=2.
// Parity expectations follow X74_TX_PARITY_EN as compiled.

module tb_x74_194_tx_ctrl;

    localparam int   A_DIV  = 4;
    localparam int   A_STOP = 1;
    localparam logic A_ODD  = 1'b0;
    localparam int   B_DIV  = 1;
    localparam int   B_STOP = 2;
    localparam logic B_ODD  = 1'b0;
`ifdef X74_TX_PARITY_EN
    localparam int   P_BITS = 1;
`else
    localparam int   P_BITS = 0;
`endif

    typedef struct packed {
        logic       line;
        logic       busy;
        logic       ready;
        logic       done;
        logic       clr_n;
        logic       sli;
        logic [1:0] mode;   // {S0, S1}
    } sig_t;

    typedef struct packed {
        sig_t       sig;
        logic       chk_nib;
        logic [3:0] nib;    // {a, b, c, d}
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_data = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready, a_s0, a_s1, a_pa, a_pb, a_pc, a_pd, a_sli, a_clr_n;
    logic       a_sr_out, a_line, a_busy, a_done;
    logic [3:0] a_q;

    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready, b_s0, b_s1, b_pa, b_pb, b_pc, b_pd, b_sli, b_clr_n;
    logic       b_sr_out, b_line, b_busy, b_done;
    logic [3:0] b_q;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    x74_194_tx_ctrl #(.BIT_DIV(A_DIV), .STOP_BITS(A_STOP), .PARITY_ODD(0)) u_dut_a (
        .CLK(clk), .CLR(clr), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .sr_s0(a_s0), .sr_s1(a_s1), .sr_a(a_pa), .sr_b(a_pb), .sr_c(a_pc), .sr_d(a_pd),
        .sr_sli(a_sli), .sr_clr_n(a_clr_n), .sr_out(a_sr_out),
        .tx_line(a_line), .busy(a_busy), .done(a_done)
    );

    x74_194_tx_ctrl #(.BIT_DIV(B_DIV), .STOP_BITS(B_STOP), .PARITY_ODD(0)) u_dut_b (
        .CLK(clk), .CLR(clr), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .sr_s0(b_s0), .sr_s1(b_s1), .sr_a(b_pa), .sr_b(b_pb), .sr_c(b_pc), .sr_d(b_pd),
        .sr_sli(b_sli), .sr_clr_n(b_clr_n), .sr_out(b_sr_out),
        .tx_line(b_line), .busy(b_busy), .done(b_done)
    );

    // x74_194 model for DUT A: sync clear, load a->Q[3], shift toward Q[3].
    always @(posedge clk) begin
        if (!a_clr_n) a_q <= 4'h0;
        else case ({a_s0, a_s1})
            2'b11:   a_q <= {a_pa, a_pb, a_pc, a_pd};
            2'b01:   a_q <= {a_q[2:0], a_sli};
            2'b10:   a_q <= {a_sli, a_q[3:1]};
            default: a_q <= a_q;
        endcase
    end
    assign a_sr_out = a_q[3];

    // x74_194 model for DUT B.
    always @(posedge clk) begin
        if (!b_clr_n) b_q <= 4'h0;
        else case ({b_s0, b_s1})
            2'b11:   b_q <= {b_pa, b_pb, b_pc, b_pd};
            2'b01:   b_q <= {b_q[2:0], b_sli};
            2'b10:   b_q <= {b_sli, b_q[3:1]};
            default: b_q <= b_q;
        endcase
    end
    assign b_sr_out = b_q[3];

    function automatic exp_t sample_a();
        exp_t o;
        o.sig.line  = a_line;
        o.sig.busy  = a_busy;
        o.sig.ready = a_ready;
        o.sig.done  = a_done;
        o.sig.clr_n = a_clr_n;
        o.sig.sli   = a_sli;
        o.sig.mode  = {a_s0, a_s1};
        o.chk_nib   = 1'b0;
        o.nib       = {a_pa, a_pb, a_pc, a_pd};
        return o;
    endfunction

    function automatic exp_t sample_b();
        exp_t o;
        o.sig.line  = b_line;
        o.sig.busy  = b_busy;
        o.sig.ready = b_ready;
        o.sig.done  = b_done;
        o.sig.clr_n = b_clr_n;
        o.sig.sli   = b_sli;
        o.sig.mode  = {b_s0, b_s1};
        o.chk_nib   = 1'b0;
        o.nib       = {b_pa, b_pb, b_pc, b_pd};
        return o;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.sig.line  = 1'b1;
        e.sig.ready = 1'b1;
        e.chk_nib   = 1'b1;
        e.nib       = 4'h0;
        return e;
    endfunction

    task automatic push_idle(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) q_a.push_back(idle_exp());
            else            q_b.push_back(idle_exp());
        end
    endtask

    // Per-clock expectations for one whole frame of byte b.
    task automatic push_frame(input int which, input logic [7:0] b);
        int   div, nstop, nbits;
        logic odd, bitv;
        exp_t e;
        div   = (which == 0) ? A_DIV : B_DIV;
        nstop = (which == 0) ? A_STOP : B_STOP;
        odd   = (which == 0) ? A_ODD : B_ODD;
        nbits = 9 + P_BITS + nstop;
        for (int k = 0; k < nbits; k++) begin
            if (k == 0)                       bitv = 1'b0;
            else if (k <= 8)                  bitv = b[8 - k];
            else if ((P_BITS == 1) && (k == 9)) bitv = (^b) ^ odd;
            else                              bitv = 1'b1;
            for (int c = 0; c < div; c++) begin
                e = '0;
                e.sig.line  = bitv;
                e.sig.busy  = 1'b1;
                e.sig.clr_n = 1'b1;
                e.sig.mode  = 2'b00;
                if (c == div - 1) begin
                    if (k == 0) begin
                        e.sig.mode = 2'b11; e.chk_nib = 1'b1; e.nib = b[7:4];
                    end else if (k == 4) begin
                        e.sig.mode = 2'b11; e.chk_nib = 1'b1; e.nib = b[3:0];
                    end else if ((k >= 1) && (k <= 7)) begin
                        e.sig.mode = 2'b01;
                    end
                    if (k == nbits - 1) e.sig.done = 1'b1;
                end
                if (which == 0) q_a.push_back(e);
                else            q_b.push_back(e);
            end
        end
    endtask

    task automatic test_reset;
        exp_t e, o;
        @(negedge clk);
        e = idle_exp();
        o = sample_a();
        checks++;
        if ((o.sig !== e.sig) || (o.nib !== e.nib)) begin
            errors++;
            $display("FAIL reset_a: got sig=%b nib=%h, expected sig=%b nib=%h", o.sig, o.nib, e.sig, e.nib);
        end
        o = sample_b();
        checks++;
        if ((o.sig !== e.sig) || (o.nib !== e.nib)) begin
            errors++;
            $display("FAIL reset_b: got sig=%b nib=%h, expected sig=%b nib=%h", o.sig, o.nib, e.sig, e.nib);
        end
        clr = 1'b0;
        push_idle(0, 20);
        push_idle(1, 20);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e = q_a.pop_front(); o = sample_a();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL idle_a clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i, o.sig, o.nib, e.sig, e.nib);
            end
            e = q_b.pop_front(); o = sample_b();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL idle_b clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i, o.sig, o.nib, e.sig, e.nib);
            end
        end
        $display("reset and 20 idle clocks checked");
    endtask

    task automatic test_single_frame;
        exp_t e, o;
        int   i;
        @(negedge clk);
        a_data = 8'hA5; a_valid = 1'b1;
        push_frame(0, 8'hA5);
        push_idle(0, 1);
        i = 0;
        while (q_a.size() > 0) begin
            @(negedge clk);
            if (i == 0) a_valid = 1'b0;
            e = q_a.pop_front(); o = sample_a();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL single_a5 clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i + 1, o.sig, o.nib, e.sig, e.nib);
            end
            i++;
        end
        $display("frame A byte a5 sent, %0d clocks checked", i);
    endtask

    task automatic test_hold_data;
        exp_t e, o;
        int   i;
        @(negedge clk);
        a_data = 8'h5A; a_valid = 1'b1;
        push_frame(0, 8'h5A);
        push_idle(0, 1);
        i = 0;
        while (q_a.size() > 0) begin
            @(negedge clk);
            if (i == 0)  a_valid = 1'b0;
            if (i == 3)  a_data  = 8'hC3;
            if (i == 20) a_data  = 8'hFF;
            e = q_a.pop_front(); o = sample_a();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL hold_data clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i + 1, o.sig, o.nib, e.sig, e.nib);
            end
            i++;
        end
        $display("frame A byte 5a sent with in_data changing mid-frame, %0d clocks checked", i);
    endtask

    task automatic test_back_to_back;
        exp_t e, o;
        int   i, len;
        len = (9 + P_BITS + A_STOP) * A_DIV;
        @(negedge clk);
        a_data = 8'hA5; a_valid = 1'b1;
        push_frame(0, 8'hA5);
        push_idle(0, 1);
        push_frame(0, 8'h07);
        push_idle(0, 1);
        i = 0;
        while (q_a.size() > 0) begin
            @(negedge clk);
            if (i == 0)       a_data  = 8'h07;
            if (i == len + 1) a_valid = 1'b0;
            e = q_a.pop_front(); o = sample_a();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL back_to_back clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i + 1, o.sig, o.nib, e.sig, e.nib);
            end
            i++;
        end
        $display("frames A bytes a5,07 sent back to back, %0d clocks checked", i);
    endtask

    task automatic test_fast_frame;
        exp_t e, o;
        int   i;
        @(negedge clk);
        b_data = 8'hFF; b_valid = 1'b1;
        push_frame(1, 8'hFF);
        push_idle(1, 1);
        i = 0;
        while (q_b.size() > 0) begin
            @(negedge clk);
            if (i == 0) b_valid = 1'b0;
            e = q_b.pop_front(); o = sample_b();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL fast_ff clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i, o.sig, o.nib, e.sig, e.nib);
            end
            i++;
        end
        $display("frame B byte ff sent (BIT_DIV=1, 2 stop bits), %0d clocks checked", i);
    endtask

    task automatic test_abort;
        exp_t e, o;
        int   i;
        @(negedge clk);
        a_data = 8'h3C; a_valid = 1'b1;
        push_frame(0, 8'h3C);
        i = 0;
        // Frame clock 25 sits inside data bit 5 (bit_idx 5) at BIT_DIV=4.
        while (i < 26) begin
            @(negedge clk);
            if (i == 0) a_valid = 1'b0;
            e = q_a.pop_front(); o = sample_a();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL abort_pre clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i, o.sig, o.nib, e.sig, e.nib);
            end
            i++;
        end
        #2 clr = 1'b1;
        #1;
        e = idle_exp(); o = sample_a();
        checks++;
        if ((o.sig !== e.sig) || (o.nib !== e.nib)) begin
            errors++;
            $display("FAIL abort_async: got sig=%b nib=%h, expected sig=%b nib=%h", o.sig, o.nib, e.sig, e.nib);
        end
        q_a.delete();
        @(negedge clk);
        clr = 1'b0;
        push_idle(0, 2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = q_a.pop_front(); o = sample_a();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL abort_idle clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", k, o.sig, o.nib, e.sig, e.nib);
            end
        end
        $display("frame A byte 3c aborted by CLR in data bit 5");
        a_data = 8'h81; a_valid = 1'b1;
        push_frame(0, 8'h81);
        push_idle(0, 1);
        i = 0;
        while (q_a.size() > 0) begin
            @(negedge clk);
            if (i == 0) a_valid = 1'b0;
            e = q_a.pop_front(); o = sample_a();
            checks++;
            if ((o.sig !== e.sig) || (e.chk_nib && (o.nib !== e.nib))) begin
                errors++;
                $display("FAIL abort_next clk %0d: got sig=%b nib=%h, expected sig=%b nib=%h", i + 1, o.sig, o.nib, e.sig, e.nib);
            end
            i++;
        end
        $display("frame A byte 81 sent after abort, %0d clocks checked", i);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_hold_data();
        test_back_to_back();
        test_fast_frame();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
